// File: rtl/ctrl_pkg.sv
// Decode/control encodings shared by the ID stage and its decoder.
// Holds opcode constants, field encodings and the registered control bundle type.
package ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] SEXT_S     = 3'b000;
  localparam logic [2:0] SEXT_I     = 3'b001;
  localparam logic [2:0] SEXT_B     = 3'b010;
  localparam logic [2:0] SEXT_ISH   = 3'b011;
  localparam logic [2:0] SEXT_U     = 3'b100;
  localparam logic [2:0] SEXT_J     = 3'b110;
  localparam logic [2:0] SEXT_NONE  = 3'b111;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLL    = 4'h5;
  localparam logic [3:0] ALU_SRL    = 4'h6;
  localparam logic [3:0] ALU_SRA    = 4'h7;
  localparam logic [3:0] ALU_SLT    = 4'h8;
  localparam logic [3:0] ALU_SLTU   = 4'h9;
  localparam logic [3:0] ALU_MUL    = 4'hA;

  localparam logic [1:0] WD_ALU     = 2'b00;
  localparam logic [1:0] WD_MEM     = 2'b01;
  localparam logic [1:0] WD_PC4     = 2'b10;
  localparam logic [1:0] WD_IMM     = 2'b11;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] sext_op;
    logic [3:0] alu_op;
    logic [1:0] wd_sel;
    logic       rf_we;
    logic       alua_sel;
    logic       alub_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       is_branch;
    logic       is_jump;
    logic [2:0] br_type;
    logic       illegal;
  } ctrl_t;

  // funct3 -> ALU op for the base (funct7 == 0) register/immediate forms.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I(+optional MUL) decoder: instruction word -> control bundle.
// Zero latency, no state; unused register fields are reported as 0.
module id_decode
  import ctrl_pkg::*;
#(
  parameter int ENABLE_MUL = 0
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic       has_rd;
  logic       u1;
  logic       u2;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    ctrl   = '0;
    legal  = 1'b0;
    has_rd = 1'b0;
    u1     = 1'b0;
    u2     = 1'b0;
    case (opc)
      OPC_OP: begin
        legal = 1'b1; has_rd = 1'b1; u1 = 1'b1; u2 = 1'b1;
        ctrl.sext_op = SEXT_NONE;
        ctrl.wd_sel  = WD_ALU;
        if (f7 == 7'b0000000)                        ctrl.alu_op = alu_from_f3(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)   ctrl.alu_op = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)   ctrl.alu_op = ALU_SRA;
        else if (ENABLE_MUL != 0 && f7 == 7'b0000001 && f3 == 3'b000) ctrl.alu_op = ALU_MUL;
        else legal = 1'b0;
      end
      OPC_OP_IMM: begin
        legal = 1'b1; has_rd = 1'b1; u1 = 1'b1;
        ctrl.alub_sel = 1'b1;
        ctrl.wd_sel   = WD_ALU;
        ctrl.sext_op  = SEXT_I;
        ctrl.alu_op   = alu_from_f3(f3);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shift-immediates reuse the funct7 slot to pick logical vs arithmetic.
          ctrl.sext_op = SEXT_ISH;
          if (f3 == 3'b101 && f7 == 7'b0100000) ctrl.alu_op = ALU_SRA;
          else if (f7 != 7'b0000000)            legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        legal = (f3 == 3'b010); has_rd = 1'b1; u1 = 1'b1;
        ctrl.sext_op  = SEXT_I;
        ctrl.alub_sel = 1'b1;
        ctrl.mem_rd   = 1'b1;
        ctrl.wd_sel   = WD_MEM;
      end
      OPC_STORE: begin
        legal = (f3 == 3'b010); u1 = 1'b1; u2 = 1'b1;
        ctrl.sext_op  = SEXT_S;
        ctrl.alub_sel = 1'b1;
        ctrl.mem_wr   = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); u1 = 1'b1; u2 = 1'b1;
        ctrl.sext_op   = SEXT_B;
        ctrl.alua_sel  = 1'b1;
        ctrl.alub_sel  = 1'b1;
        ctrl.is_branch = 1'b1;
        ctrl.br_type   = f3;
      end
      OPC_LUI: begin
        legal = 1'b1; has_rd = 1'b1;
        ctrl.sext_op  = SEXT_U;
        ctrl.alub_sel = 1'b1;
        ctrl.wd_sel   = WD_IMM;
      end
      OPC_AUIPC: begin
        legal = 1'b1; has_rd = 1'b1;
        ctrl.sext_op  = SEXT_U;
        ctrl.alua_sel = 1'b1;
        ctrl.alub_sel = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; has_rd = 1'b1;
        ctrl.sext_op  = SEXT_J;
        ctrl.alua_sel = 1'b1;
        ctrl.alub_sel = 1'b1;
        ctrl.is_jump  = 1'b1;
        ctrl.wd_sel   = WD_PC4;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); has_rd = 1'b1; u1 = 1'b1;
        ctrl.sext_op  = SEXT_I;
        ctrl.alub_sel = 1'b1;
        ctrl.is_jump  = 1'b1;
        ctrl.wd_sel   = WD_PC4;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      u1           = 1'b0;
      u2           = 1'b0;
    end else begin
      ctrl.rs1   = u1 ? inst[19:15] : 5'd0;
      ctrl.rs2   = u2 ? inst[24:20] : 5'd0;
      ctrl.rd    = has_rd ? inst[11:7] : 5'd0;
      ctrl.rf_we = has_rd && (inst[11:7] != 5'd0);
    end
    rs1_used = u1;
    rs2_used = u2;
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode stage: one instruction per cycle into an EX control bundle.
// 1-cycle latency; flush > ex_stall (hold) > load-use bubble > decode; id_ready is combinational.
module id_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ENABLE_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_sext_op,
  output logic [3:0]      ex_alu_op,
  output logic [1:0]      ex_wd_sel,
  output logic            ex_rf_we,
  output logic            ex_alua_sel,
  output logic            ex_alub_sel,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_is_branch,
  output logic            ex_is_jump,
  output logic [2:0]      ex_br_type,
  output logic            ex_illegal
);

  ctrl_t           dec_ctrl;
  logic            dec_rs1_used;
  logic            dec_rs2_used;
  ctrl_t           ex_q;
  logic            ex_valid_q;
  logic [XLEN-1:0] ex_pc_q;
  logic            hazard;

  id_decode #(.ENABLE_MUL(ENABLE_MUL)) u_decode (
    .inst     (if_inst),
    .ctrl     (dec_ctrl),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used)
  );

  // Load-use against the bundle currently held for EX; decoder zeroes unused rs fields.
  always_comb begin
    hazard = if_valid && ex_valid_q && ex_q.mem_rd && (ex_q.rd != 5'd0) &&
             ((dec_rs1_used && dec_ctrl.rs1 == ex_q.rd) ||
              (dec_rs2_used && dec_ctrl.rs2 == ex_q.rd));
    id_ready = flush || (!ex_stall && !hazard);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
    end else if (flush) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
    end else if (!ex_stall) begin
      if (hazard || !if_valid) begin
        ex_q       <= '0;
        ex_valid_q <= 1'b0;
        ex_pc_q    <= '0;
      end else begin
        ex_q       <= dec_ctrl;
        ex_valid_q <= 1'b1;
        ex_pc_q    <= if_pc;
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_sext_op   = ex_q.sext_op;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_wd_sel    = ex_q.wd_sel;
  assign ex_rf_we     = ex_q.rf_we;
  assign ex_alua_sel  = ex_q.alua_sel;
  assign ex_alub_sel  = ex_q.alub_sel;
  assign ex_mem_rd    = ex_q.mem_rd;
  assign ex_mem_wr    = ex_q.mem_wr;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_is_jump   = ex_q.is_jump;
  assign ex_br_type   = ex_q.br_type;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage; a second instance with ENABLE_MUL=1 covers MUL decode.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        ex_stall;
  logic        flush;

  logic        id_ready, ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_sext_op, ex_br_type;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_wd_sel;
  logic        ex_rf_we, ex_alua_sel, ex_alub_sel, ex_mem_rd, ex_mem_wr;
  logic        ex_is_branch, ex_is_jump, ex_illegal;

  logic        m_id_ready, m_ex_valid;
  logic [31:0] m_ex_pc;
  logic [4:0]  m_ex_rs1, m_ex_rs2, m_ex_rd;
  logic [2:0]  m_ex_sext_op, m_ex_br_type;
  logic [3:0]  m_ex_alu_op;
  logic [1:0]  m_ex_wd_sel;
  logic        m_ex_rf_we, m_ex_alua_sel, m_ex_alub_sel, m_ex_mem_rd, m_ex_mem_wr;
  logic        m_ex_is_branch, m_ex_is_jump, m_ex_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ctrl_stage #(.XLEN(32), .ENABLE_MUL(0)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_sext_op(ex_sext_op), .ex_alu_op(ex_alu_op), .ex_wd_sel(ex_wd_sel),
    .ex_rf_we(ex_rf_we), .ex_alua_sel(ex_alua_sel), .ex_alub_sel(ex_alub_sel),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_br_type(ex_br_type), .ex_illegal(ex_illegal)
  );

  id_ctrl_stage #(.XLEN(32), .ENABLE_MUL(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(m_id_ready), .ex_stall(ex_stall), .flush(flush), .ex_valid(m_ex_valid),
    .ex_pc(m_ex_pc), .ex_rs1(m_ex_rs1), .ex_rs2(m_ex_rs2), .ex_rd(m_ex_rd),
    .ex_sext_op(m_ex_sext_op), .ex_alu_op(m_ex_alu_op), .ex_wd_sel(m_ex_wd_sel),
    .ex_rf_we(m_ex_rf_we), .ex_alua_sel(m_ex_alua_sel), .ex_alub_sel(m_ex_alub_sel),
    .ex_mem_rd(m_ex_mem_rd), .ex_mem_wr(m_ex_mem_wr), .ex_is_branch(m_ex_is_branch),
    .ex_is_jump(m_ex_is_jump), .ex_br_type(m_ex_br_type), .ex_illegal(m_ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_inst = 32'h0; if_pc = 32'h0;
    ex_stall = 1'b0; flush = 1'b0;
    #2;
    chk("rst_valid", ex_valid, 0);
    chk("rst_rfwe", ex_rf_we, 0);
    chk("rst_ready", id_ready, 1);
    tick(); tick();
    rst_n = 1'b1;

    // add x3,x1,x2
    drive(1, 32'h002081B3, 32'h100);
    chk("add_ready", id_ready, 1);
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_alu", ex_alu_op, 0);
    chk("add_wd", ex_wd_sel, 0);
    chk("add_rfwe", ex_rf_we, 1);
    chk("add_alub", ex_alub_sel, 0);
    chk("add_rd", ex_rd, 3);
    chk("add_rs", {ex_rs1, ex_rs2}, {5'd1, 5'd2});
    chk("add_pc", ex_pc, 32'h100);
    chk("add_sext", ex_sext_op, 3'b111);

    // lw x5,0(x1) followed by dependent add x6,x5,x1
    drive(1, 32'h0000A283, 32'h104);
    tick();
    chk("lw_memrd", ex_mem_rd, 1);
    chk("lw_wd", ex_wd_sel, 1);
    chk("lw_rs2", ex_rs2, 0);
    drive(1, 32'h00128333, 32'h108);
    chk("hz_ready", id_ready, 0);
    tick();
    chk("hz_bubble", ex_valid, 0);
    chk("hz_bub_rfwe", ex_rf_we, 0);
    chk("hz_ready2", id_ready, 1);
    tick();
    chk("hz_add_valid", ex_valid, 1);
    chk("hz_add_rd", ex_rd, 6);
    chk("hz_add_pc", ex_pc, 32'h108);

    // lw x5 then lui x5: U-type reads nothing, no hazard
    drive(1, 32'h0000A283, 32'h10C);
    tick();
    drive(1, 32'h000052B7, 32'h110);
    chk("lui_nohz_ready", id_ready, 1);
    tick();
    chk("lui_wd", ex_wd_sel, 3);
    chk("lui_sext", ex_sext_op, 3'b100);

    // lw x0 then add x6,x0,x1: x0 never creates a hazard
    drive(1, 32'h0000A003, 32'h114);
    tick();
    chk("lwx0_rfwe", ex_rf_we, 0);
    drive(1, 32'h00100333, 32'h118);
    chk("lwx0_ready", id_ready, 1);

    // beq with flush, then without
    drive(1, 32'h00208463, 32'h120);
    flush = 1'b1;
    #1;
    chk("flush_ready", id_ready, 1);
    tick();
    chk("flush_bubble", ex_valid, 0);
    chk("flush_br", ex_is_branch, 0);
    flush = 1'b0;
    tick();
    chk("beq_valid", ex_valid, 1);
    chk("beq_br", ex_is_branch, 1);
    chk("beq_type", ex_br_type, 0);
    chk("beq_sext", ex_sext_op, 3'b010);
    chk("beq_alua", ex_alua_sel, 1);
    chk("beq_rfwe", ex_rf_we, 0);

    // ex_stall for three cycles
    drive(1, 32'h002081B3, 32'h200);
    tick();
    drive(1, 32'h00128333, 32'h204);
    ex_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", id_ready, 0);
      tick();
      chk("stall_rd", ex_rd, 3);
      chk("stall_pc", ex_pc, 32'h200);
    end
    ex_stall = 1'b0;
    #1;
    chk("unstall_ready", id_ready, 1);
    tick();
    chk("unstall_rd", ex_rd, 6);
    chk("unstall_pc", ex_pc, 32'h204);

    // flush and stall together: flush wins
    ex_stall = 1'b1; flush = 1'b1;
    #1;
    chk("fs_ready", id_ready, 1);
    tick();
    chk("fs_valid", ex_valid, 0);
    ex_stall = 1'b0; flush = 1'b0;

    // mul on both instances
    drive(1, 32'h022081B3, 32'h300);
    tick();
    chk("mul0_valid", ex_valid, 1);
    chk("mul0_illegal", ex_illegal, 1);
    chk("mul0_rfwe", ex_rf_we, 0);
    chk("mul1_alu", m_ex_alu_op, 4'hA);
    chk("mul1_rfwe", m_ex_rf_we, 1);
    chk("mul1_illegal", m_ex_illegal, 0);

    drive(1, 32'hFFFFFFFF, 32'h304);
    tick();
    chk("ff_illegal", ex_illegal, 1);
    chk("ff_valid", ex_valid, 1);
    chk("ff_memrd", ex_mem_rd, 0);

    drive(1, 32'h00100013, 32'h308);
    tick();
    chk("addi0_illegal", ex_illegal, 0);
    chk("addi0_rfwe", ex_rf_we, 0);
    chk("addi0_alub", ex_alub_sel, 1);

    // jal x1,8
    drive(1, 32'h008000EF, 32'h30C);
    tick();
    chk("jal_jump", ex_is_jump, 1);
    chk("jal_wd", ex_wd_sel, 2);
    chk("jal_sext", ex_sext_op, 3'b110);
    chk("jal_rfwe", ex_rf_we, 1);

    drive(0, 32'h002081B3, 32'h310);
    tick();
    chk("idle_valid", ex_valid, 0);

    // asynchronous reset during a stall
    drive(1, 32'h002081B3, 32'h400);
    tick();
    ex_stall = 1'b1;
    tick();
    chk("pre_rst_valid", ex_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_rd", ex_rd, 0);
    ex_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", ex_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
